// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
package flash_arb_pkg;

    // Arbiter sequencing: idle/arbitrate, flash transfer, end-of-transfer, respond, hold.
    typedef enum logic [2:0] {
        IDLE,
        FLASH_REQ,
        FLASH_EOT,
        RESPOND,
        HOLD
    } state_t;

    // Requester identity, also used as the round-robin memory.
    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    // Flash reads are always whole words; byte offset bits are forced to zero.
    localparam logic [31:0] FLASH_WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/flash_word_buffer.sv
// One-word last-read buffer: tag/data/valid with lookup, fill and flush.
// Flush takes priority over a fill landing in the same cycle.
module flash_word_buffer #(
    parameter int TAG_BITS = 22
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic                i_fill,
    input  logic [TAG_BITS-1:0] i_fill_tag,
    input  logic [31:0]         i_fill_data,
    input  logic [TAG_BITS-1:0] i_lookup_tag,
    output logic                o_hit,
    output logic [31:0]         o_data
);

    logic                r_valid;
    logic [TAG_BITS-1:0] r_tag;
    logic [31:0]         r_data;

    // Valid bit: flush always wins, otherwise a fill marks the entry usable.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_data <= i_fill_data;
            end
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI flash read engine,
// with an optional one-word last-read buffer. ADDR_BITS must be below 32.
module spi_flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter bit BUFFER_ENABLE = 1'b1,
    parameter int ADDR_BITS     = 24
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_a_request,
    input  logic [31:0] i_a_address,
    output logic [31:0] o_a_rdata,
    output logic        o_a_ready,
    input  logic        i_b_request,
    input  logic [31:0] i_b_address,
    output logic [31:0] o_b_rdata,
    output logic        o_b_ready,
    input  logic        i_flush,
    output logic        o_flash_request,
    output logic [31:0] o_flash_address,
    input  logic [31:0] i_flash_rdata,
    input  logic        i_flash_ready
);

    localparam int TAG_BITS = ADDR_BITS - 2;

    state_t              r_state;
    port_t               r_grant;
    port_t               r_last_grant;
    logic [TAG_BITS-1:0] r_word;
    logic [31:0]         r_resp;

    port_t               w_grant;
    logic [31:0]         w_req_addr;
    logic [TAG_BITS-1:0] w_req_tag;
    logic [31:0]         w_flash_addr;
    logic                w_any_req;
    logic                w_granted_req;
    logic                w_buf_hit;
    logic [31:0]         w_buf_data;
    logic                w_hit;
    logic                w_fill;
    logic                w_unused_hi;

    // Round-robin pick: on a tie the port that did not win last time goes first.
    always_comb begin
        w_grant = PORT_A;
        if (i_a_request && i_b_request) begin
            w_grant = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (i_b_request) begin
            w_grant = PORT_B;
        end
    end

    assign w_req_addr    = (w_grant == PORT_A) ? i_a_address : i_b_address;
    assign w_req_tag     = w_req_addr[ADDR_BITS-1:2];
    assign w_flash_addr  = 32'(w_req_addr[ADDR_BITS-1:0]) & FLASH_WORD_MASK;
    assign w_unused_hi   = |w_req_addr[31:ADDR_BITS];
    assign w_any_req     = i_a_request | i_b_request;
    assign w_granted_req = (r_grant == PORT_A) ? i_a_request : i_b_request;
    // A flush arriving in the arbitration cycle must not let stale data through.
    assign w_hit         = BUFFER_ENABLE && w_buf_hit && !i_flush;
    assign w_fill        = BUFFER_ENABLE && (r_state == FLASH_REQ) && i_flash_ready;

    flash_word_buffer #(
        .TAG_BITS (TAG_BITS)
    ) u_buffer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_fill       (w_fill),
        .i_fill_tag   (r_word),
        .i_fill_data  (i_flash_rdata),
        .i_lookup_tag (w_req_tag),
        .o_hit        (w_buf_hit),
        .o_data       (w_buf_data)
    );

    // Arbitration, flash handshake and port handshake sequencing with registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= IDLE;
            r_grant         <= PORT_A;
            r_last_grant    <= PORT_B;
            r_word          <= '0;
            r_resp          <= '0;
            o_a_ready       <= 1'b0;
            o_b_ready       <= 1'b0;
            o_a_rdata       <= '0;
            o_b_rdata       <= '0;
            o_flash_request <= 1'b0;
            o_flash_address <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_word       <= w_req_tag;
                        if (w_hit) begin
                            r_resp  <= w_buf_data;
                            r_state <= RESPOND;
                        end else begin
                            o_flash_request <= 1'b1;
                            o_flash_address <= w_flash_addr;
                            r_state         <= FLASH_REQ;
                        end
                    end
                end
                FLASH_REQ: begin
                    if (i_flash_ready) begin
                        r_resp          <= i_flash_rdata;
                        o_flash_request <= 1'b0;
                        r_state         <= FLASH_EOT;
                    end
                end
                FLASH_EOT: begin
                    if (!i_flash_ready) begin
                        r_state <= RESPOND;
                    end
                end
                RESPOND: begin
                    // A requester that gave up early gets no ready at all.
                    if (w_granted_req) begin
                        if (r_grant == PORT_A) begin
                            o_a_ready <= 1'b1;
                            o_a_rdata <= r_resp;
                        end else begin
                            o_b_ready <= 1'b1;
                            o_b_rdata <= r_resp;
                        end
                        r_state <= HOLD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!w_granted_req) begin
                        o_a_ready <= 1'b0;
                        o_b_ready <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: one buffered instance, one unbuffered instance,
// each with its own fixed-latency flash responder.
module tb_spi_flash_arbiter;

    localparam int          LAT  = 80;
    localparam logic [31:0] MASK = 32'h00FF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        a_req0, b_req0, a_req1, b_req1;
    logic [31:0] a_addr0, b_addr0, a_addr1, b_addr1;
    logic        a_rdy0, b_rdy0, a_rdy1, b_rdy1;
    logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
    logic        freq0, freq1;
    logic [31:0] faddr0, faddr1;
    logic [1:0]  frdy;
    logic [31:0] fdata [2];
    int          fcnt [2];
    logic [31:0] flog0 [$];
    logic [31:0] flog1 [$];
    logic [3:0]  preq;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        mvalid [2];
    logic [21:0] mtag [2];

    spi_flash_arbiter #(.BUFFER_ENABLE(1'b1), .ADDR_BITS(24)) dut0 (
        .i_clock(clk), .i_reset(rst_n),
        .i_a_request(a_req0), .i_a_address(a_addr0), .o_a_rdata(a_rd0), .o_a_ready(a_rdy0),
        .i_b_request(b_req0), .i_b_address(b_addr0), .o_b_rdata(b_rd0), .o_b_ready(b_rdy0),
        .i_flush(flush), .o_flash_request(freq0), .o_flash_address(faddr0),
        .i_flash_rdata(fdata[0]), .i_flash_ready(frdy[0])
    );

    spi_flash_arbiter #(.BUFFER_ENABLE(1'b0), .ADDR_BITS(24)) dut1 (
        .i_clock(clk), .i_reset(rst_n),
        .i_a_request(a_req1), .i_a_address(a_addr1), .o_a_rdata(a_rd1), .o_a_ready(a_rdy1),
        .i_b_request(b_req1), .i_b_address(b_addr1), .o_b_rdata(b_rd1), .o_b_ready(b_rdy1),
        .i_flush(flush), .o_flash_request(freq1), .o_flash_address(faddr1),
        .i_flash_rdata(fdata[1]), .i_flash_ready(frdy[1])
    );

    // Flash contents: one marker word at 0x100, a pattern everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [21:0] w;
        w = a[23:2];
        if (w == 22'h40) return 32'hDEADBEEF;
        return 32'hC0DE_0000 ^ {10'h0, w};
    endfunction

    function automatic logic get_freq(input int k);
        return (k == 0) ? freq0 : freq1;
    endfunction
    function automatic logic [31:0] get_faddr(input int k);
        return (k == 0) ? faddr0 : faddr1;
    endfunction
    function automatic logic get_rdy(input int k, input int p);
        case (k * 2 + p)
            0: return a_rdy0;
            1: return b_rdy0;
            2: return a_rdy1;
            default: return b_rdy1;
        endcase
    endfunction
    function automatic logic [31:0] get_rdata(input int k, input int p);
        case (k * 2 + p)
            0: return a_rd0;
            1: return b_rd0;
            2: return a_rd1;
            default: return b_rd1;
        endcase
    endfunction
    function automatic logic get_req(input int k, input int p);
        case (k * 2 + p)
            0: return a_req0;
            1: return b_req0;
            2: return a_req1;
            default: return b_req1;
        endcase
    endfunction
    function automatic logic [31:0] get_addr(input int k, input int p);
        case (k * 2 + p)
            0: return a_addr0;
            1: return b_addr0;
            2: return a_addr1;
            default: return b_addr1;
        endcase
    endfunction
    function automatic int logsize(input int k);
        return (k == 0) ? flog0.size() : flog1.size();
    endfunction
    function automatic logic [31:0] logat(input int k, input int i);
        if (k == 0) return (i < flog0.size()) ? flog0[i] : 32'hFFFF_FFFF;
        return (i < flog1.size()) ? flog1[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic set_req(input int k, input int p, input logic r, input logic [31:0] a);
        case (k * 2 + p)
            0: begin a_req0 = r; a_addr0 = a; end
            1: begin b_req0 = r; b_addr0 = a; end
            2: begin a_req1 = r; a_addr1 = a; end
            default: begin b_req1 = r; b_addr1 = a; end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mvalid[k] = 1'b0;
            mtag[k]   = '0;
        end
    endtask

    // Flash responders: ready LAT cycles after request is seen, held until request drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frdy    <= 2'b00;
            fcnt[0] <= 0;
            fcnt[1] <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (frdy[k]) begin
                    if (!get_freq(k)) frdy[k] <= 1'b0;
                end else if (get_freq(k)) begin
                    if (fcnt[k] == LAT - 1) begin
                        frdy[k]  <= 1'b1;
                        fdata[k] <= mem_word(get_faddr(k));
                        fcnt[k]  <= 0;
                        if (k == 0) flog0.push_back(get_faddr(k));
                        else        flog1.push_back(get_faddr(k));
                    end else begin
                        fcnt[k] <= fcnt[k] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        preq <= {b_req1, a_req1, b_req0, a_req0};
    end

    // Every-cycle check of both instances against the protocol rules.
    initial begin
        logic ok;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    check("in_reset_flash_req", 32'(get_freq(k)), 32'd0);
                    check("in_reset_a_ready", 32'(get_rdy(k, 0)), 32'd0);
                    check("in_reset_b_ready", 32'(get_rdy(k, 1)), 32'd0);
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        if (get_rdy(k, p)) begin
                            check("ready_needs_request", 32'(preq[k * 2 + p]), 32'd1);
                            check("ready_rdata", get_rdata(k, p), mem_word(get_addr(k, p)));
                        end
                    end
                    if (get_freq(k)) begin
                        ok = (get_req(k, 0) && get_faddr(k) == (get_addr(k, 0) & MASK)) ||
                             (get_req(k, 1) && get_faddr(k) == (get_addr(k, 1) & MASK));
                        check("flash_addr_from_pending", 32'(ok), 32'd1);
                    end
                end
            end
        end
    end

    // One read on one port; returns cycles from request to ready, the data and ready time.
    task automatic do_read(input int k, input int p, input logic [31:0] addr, input int hold,
                           output int lat, output logic [31:0] data, output int t_rdy);
        set_req(k, p, 1'b1, addr);
        lat = 0;
        data = '0;
        t_rdy = 0;
        while (lat < 400 && !get_rdy(k, p)) begin
            @(negedge clk);
            lat++;
        end
        if (!get_rdy(k, p)) begin
            check("ready_timeout", 32'd0, 32'd1);
            set_req(k, p, 1'b0, addr);
            @(negedge clk);
            return;
        end
        data  = get_rdata(k, p);
        t_rdy = cyc;
        repeat (hold) begin
            @(negedge clk);
            check("ready_held", 32'(get_rdy(k, p)), 32'd1);
        end
        set_req(k, p, 1'b0, addr);
        @(negedge clk);
        check("ready_fall", 32'(get_rdy(k, p)), 32'd0);
    endtask

    // Single uncontended read checked against the buffer model.
    task automatic txn(input int k, input int p, input logic [31:0] addr, input int hold,
                       output int lat, output logic [31:0] data);
        logic hit;
        int   n0;
        int   t;
        hit = mvalid[k] && (mtag[k] == addr[23:2]);
        n0  = logsize(k);
        do_read(k, p, addr, hold, lat, data, t);
        check("latency", 32'(lat), hit ? 32'd2 : 32'(LAT + 5));
        check("data", data, mem_word(addr));
        check("flash_accesses", 32'(logsize(k)), 32'(n0 + (hit ? 0 : 1)));
        if (!hit) begin
            check("flash_address", logat(k, logsize(k) - 1), addr & MASK);
            mvalid[k] = (k == 0);
            mtag[k]   = addr[23:2];
        end
    endtask

    task automatic flush_on_fill();
        int n;
        n = 0;
        while (n < 200 && !frdy[0]) begin
            @(negedge clk);
            n++;
        end
        check("fill_seen", 32'(frdy[0]), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    int          lat, la1, la2, lb, ta1, ta2, tb_t, n0, n;
    logic [31:0] data, da1, da2, db;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        set_req(0, 0, 1'b0, '0);
        set_req(0, 1, 1'b0, '0);
        set_req(1, 0, 1'b0, '0);
        set_req(1, 1, 1'b0, '0);
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_a_ready", 32'(a_rdy0), 32'd0);
        check("rst_b_ready", 32'(b_rdy0), 32'd0);
        check("rst_a_rdata", a_rd0, 32'd0);
        check("rst_b_rdata", b_rd0, 32'd0);
        check("rst_flash_req", 32'(freq0), 32'd0);
        check("rst_flash_addr", faddr0, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single miss, then hits on the same word through ignored address bits.
        txn(0, 0, 32'h0000_0100, 2, lat, data);
        check("t1_lat_literal", 32'(lat), 32'd85);
        check("t1_data_literal", data, 32'hDEADBEEF);
        check("t1_flash_addr_literal", logat(0, 0), 32'h0000_0100);
        txn(0, 0, 32'h0000_0102, 0, lat, data);
        check("t2_hit_lat_literal", 32'(lat), 32'd2);
        check("t2_hit_data_literal", data, 32'hDEADBEEF);
        txn(0, 1, 32'hAB00_0101, 0, lat, data);
        check("t2_b_hit_lat_literal", 32'(lat), 32'd2);

        // Contention after reset: A wins the tie, then B, then A's second read.
        reset_pulse();
        n0 = logsize(0);
        fork
            begin
                do_read(0, 0, 32'h0000_0200, 0, la1, da1, ta1);
                do_read(0, 0, 32'h0000_0280, 0, la2, da2, ta2);
            end
            do_read(0, 1, 32'h0000_0300, 0, lb, db, tb_t);
        join
        check("rr_a_first_lat", 32'(la1), 32'd85);
        check("rr_a_before_b", 32'(ta1 < tb_t), 32'd1);
        check("rr_b_before_a2", 32'(tb_t < ta2), 32'd1);
        check("rr_flash_count", 32'(logsize(0) - n0), 32'd3);
        check("rr_flash_0", logat(0, n0), 32'h0000_0200);
        check("rr_flash_1", logat(0, n0 + 1), 32'h0000_0300);
        check("rr_flash_2", logat(0, n0 + 2), 32'h0000_0280);
        check("rr_data_a1", da1, 32'hC0DE_0080);
        check("rr_data_b", db, 32'hC0DE_00C0);
        check("rr_data_a2", da2, 32'hC0DE_00A0);
        mvalid[0] = 1'b1;
        mtag[0]   = 22'hA0;

        // Flush pulse forces the buffered word to be fetched again.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_reset();
        txn(0, 0, 32'h0000_0280, 0, lat, data);
        check("flush_miss_lat_literal", 32'(lat), 32'd85);

        // Flush in the fill cycle: data still returned, buffer left invalid.
        fork
            txn(0, 0, 32'h0000_0100, 0, lat, data);
            flush_on_fill();
        join
        check("fill_flush_data_literal", data, 32'hDEADBEEF);
        mvalid[0] = 1'b0;
        txn(0, 0, 32'h0000_0100, 0, lat, data);
        check("after_fill_flush_miss_literal", 32'(lat), 32'd85);
        txn(0, 1, 32'hAB00_0103, 0, lat, data);
        check("b_hit_after_refill_literal", 32'(lat), 32'd2);

        // Reset while the flash request is outstanding.
        set_req(0, 0, 1'b1, 32'h0000_0400);
        n = 0;
        while (n < 10 && !freq0) begin
            @(negedge clk);
            n++;
        end
        check("midrst_flash_req_up", 32'(freq0), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flash_req", 32'(freq0), 32'd0);
        check("midrst_a_ready", 32'(a_rdy0), 32'd0);
        check("midrst_b_ready", 32'(b_rdy0), 32'd0);
        set_req(0, 0, 1'b0, 32'h0000_0400);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        txn(0, 0, 32'h0000_0100, 0, lat, data);
        check("midrst_then_miss_literal", 32'(lat), 32'd85);

        // Unbuffered instance: repeated reads always go to flash.
        txn(1, 0, 32'h0000_0100, 0, lat, data);
        txn(1, 1, 32'h0000_0100, 0, lat, data);
        check("nobuf_second_lat_literal", 32'(lat), 32'd85);
        check("nobuf_flash_count_literal", 32'(logsize(1)), 32'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
